// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types, constants and helpers for the AUD trace deframer
// State encoding, frame type codes and nibble-count/mask conversion used by the deframer and merge unit.
package aud_pkg;

   localparam int AUD_DW = 32;

   typedef enum logic {
      IDLE = 1'b0,
      DATA = 1'b1
   } aud_state_e;

   localparam logic [1:0] TYPE_BSRC = 2'b00;
   localparam logic [1:0] TYPE_BDST = 2'b01;
   localparam logic [1:0] TYPE_EXC  = 2'b10;
   localparam logic [1:0] TYPE_RSVD = 2'b11;

   function automatic logic [3:0] len_nibbles(input logic [1:0] len_code);
      logic [3:0] n;
      case (len_code)
         2'b00:   n = 4'd1;
         2'b01:   n = 4'd2;
         2'b10:   n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // Low 4*n bits set; eight or more nibbles covers the whole word.
   function automatic logic [AUD_DW-1:0] nib_mask(input logic [3:0] nib_cnt);
      logic [AUD_DW-1:0] m;
      if (nib_cnt >= 4'd8) begin
         m = '1;
      end else begin
         m = (32'h1 << {nib_cnt, 2'b00}) - 32'h1;
      end
      return m;
   endfunction

endpackage

// File: rtl/aud_trace_deframer_if.sv
// rtl/aud_trace_deframer_if.sv - AUD bus input and trace-word FIFO write side bundle
// The capture source/sink uses master; the deframer uses slave.
interface aud_trace_deframer_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ERR_CNT_WIDTH = 16
);
   logic                     aud_sync_n;
   logic [3:0]               aud_data;
   logic                     full_i;
   logic [DATA_WIDTH-1:0]    dat_o;
   logic                     we_o;
   logic [1:0]               type_o;
   logic                     busy_o;
   logic                     ovf_o;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_o;

   modport master (
      output aud_sync_n, aud_data, full_i,
      input  dat_o, we_o, type_o, busy_o, ovf_o, err_cnt_o
   );

   modport slave (
      input  aud_sync_n, aud_data, full_i,
      output dat_o, we_o, type_o, busy_o, ovf_o, err_cnt_o
   );
endinterface

// File: rtl/aud_addr_merge.sv
// rtl/aud_addr_merge.sv - combinational partial-address merge
// Replaces the low nib_cnt nibbles of the previous address with freshly received ones.
module aud_addr_merge
   import aud_pkg::*;
(
   input  logic [AUD_DW-1:0] last_addr_i,
   input  logic [AUD_DW-1:0] shift_i,
   input  logic [3:0]        nib_cnt_i,
   output logic [AUD_DW-1:0] new_addr_o
);
   logic [AUD_DW-1:0] mask;

   assign mask       = nib_mask(nib_cnt_i);
   assign new_addr_o = (last_addr_i & ~mask) | (shift_i & mask);
endmodule

// File: rtl/aud_trace_deframer.sv
// rtl/aud_trace_deframer.sv - AUD branch-trace deframer feeding the trace-word FIFO
// Optional protocol error counter built when AUD_ERR_CNT_EN is defined; otherwise err_cnt_o is tied 0.
module aud_trace_deframer
   import aud_pkg::*;
#(
   parameter int DATA_WIDTH    = AUD_DW,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   aud_trace_deframer_if.slave  bus
);
   aud_state_e            state_q, state_d;
   logic [1:0]            ftype_q, ftype_d;
   logic [3:0]            len_q, len_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] last_addr_q, last_addr_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic                  we_q, we_d;
   logic [1:0]            type_q, type_d;
   logic                  busy_q, busy_d;
   logic                  ovf_q, ovf_d;

   logic [DATA_WIDTH-1:0] shift_now;
   logic [DATA_WIDTH-1:0] new_addr;
   logic [3:0]            cnt_nxt;
   logic                  take_hdr;
   logic                  err_inc;
   logic [1:0]            hdr_type;
   logic [1:0]            hdr_len;

   assign hdr_type = bus.aud_data[3:2];
   assign hdr_len  = bus.aud_data[1:0];

   // Merge sees the final nibble in the same cycle it is sampled.
   aud_addr_merge u_merge (
      .last_addr_i (last_addr_q),
      .shift_i     (shift_now),
      .nib_cnt_i   (len_q),
      .new_addr_o  (new_addr)
   );

   always_comb begin
      shift_now                       = shift_q;
      shift_now[{cnt_q, 2'b00} +: 4]  = bus.aud_data;
      cnt_nxt                         = {1'b0, cnt_q} + 4'd1;

      state_d     = state_q;
      ftype_d     = ftype_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      last_addr_d = last_addr_q;
      dat_d       = dat_q;
      we_d        = 1'b0;
      type_d      = type_q;
      ovf_d       = ovf_q;
      take_hdr    = 1'b0;
      err_inc     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!bus.aud_sync_n) begin
               take_hdr = 1'b1;
            end
         end
         DATA: begin
            if (!bus.aud_sync_n) begin
               // Truncated frame: drop partial data, reuse this nibble as the next header.
               err_inc  = 1'b1;
               take_hdr = 1'b1;
            end else begin
               shift_d = shift_now;
               cnt_d   = cnt_nxt[2:0];
               if (cnt_nxt == len_q) begin
                  state_d     = IDLE;
                  last_addr_d = new_addr;
                  if (!bus.full_i) begin
                     dat_d  = new_addr;
                     type_d = ftype_q;
                     we_d   = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (take_hdr) begin
         if (hdr_type == TYPE_RSVD) begin
            err_inc = 1'b1;
            state_d = IDLE;
         end else begin
            ftype_d = hdr_type;
            len_d   = len_nibbles(hdr_len);
            cnt_d   = 3'd0;
            shift_d = '0;
            state_d = DATA;
         end
      end

      busy_d = (state_d == DATA);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ftype_q     <= TYPE_BSRC;
         len_q       <= 4'd0;
         cnt_q       <= 3'd0;
         shift_q     <= '0;
         last_addr_q <= '0;
         dat_q       <= '0;
         we_q        <= 1'b0;
         type_q      <= 2'b00;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ftype_q     <= ftype_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         last_addr_q <= last_addr_d;
         dat_q       <= dat_d;
         we_q        <= we_d;
         type_q      <= type_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.dat_o  = dat_q;
   assign bus.we_o   = we_q;
   assign bus.type_o = type_q;
   assign bus.busy_o = busy_q;
   assign bus.ovf_o  = ovf_q;

`ifdef AUD_ERR_CNT_EN
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   // Saturating; a truncation that lands on a reserved header counts once.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_inc && !(&err_cnt_q)) begin
         err_cnt_d = err_cnt_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.err_cnt_o = err_cnt_q;
`else
   logic unused_err_inc;
   assign unused_err_inc = err_inc;
   assign bus.err_cnt_o  = '0;
`endif

endmodule
